// File: rtl/flow_director_arbiter.sv
// Round-robin arbiter sharing one flow director among NUM_IN metadata producers.
// Optional per-requester accept / output-stall counters: FLOW_DIRECTOR_ARBITER_STATS_EN.
module flow_director_arbiter #(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned META_WIDTH = 512,
    parameter int unsigned SRC_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*META_WIDTH-1:0] in_meta_data,
    input  logic [NUM_IN-1:0]            in_meta_valid,
    output logic [NUM_IN-1:0]            in_meta_ready,
    output logic [META_WIDTH-1:0]        out_meta_data,
    output logic                         out_meta_valid,
    input  logic                         out_meta_ready,
    output logic [SRC_W-1:0]             out_src_id
`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
   ,output logic [NUM_IN*32-1:0]         stats_accept_cnt,
    output logic [31:0]                  stats_stall_cnt
`endif
);

    // One spare bit so rr_ptr + offset can exceed NUM_IN-1 before the explicit wrap.
    localparam int unsigned IDX_W = SRC_W + 1;
    localparam int unsigned CNT_W = 32;

    logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  valid_q, valid_d;
    logic [META_WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0]      src_q, src_d;

    logic                  load_en;
    logic                  grant_vld;
    logic [SRC_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      scan_idx;
    logic [META_WIDTH-1:0] grant_data;
    logic                  accept;

    assign load_en = !valid_q || out_meta_ready;
    assign accept  = grant_vld && load_en && !rst;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_IN.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            scan_idx = IDX_W'(rr_ptr_q) + IDX_W'(k);
            if (scan_idx >= IDX_W'(NUM_IN)) begin
                scan_idx = scan_idx - IDX_W'(NUM_IN);
            end
            if (!grant_vld && in_meta_valid[scan_idx[SRC_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                grant_data = in_meta_data[i*META_WIDTH +: META_WIDTH];
            end
        end
    end

    always_comb begin
        in_meta_ready = '0;
        if (accept) begin
            in_meta_ready[grant_idx] = 1'b1;
        end
    end

    // Accept loads the output stage; a drain without accept only drops valid.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            valid_d  = 1'b1;
            data_d   = grant_data;
            src_d    = grant_idx;
            rr_ptr_d = (grant_idx == SRC_W'(NUM_IN - 1)) ? '0 : grant_idx + SRC_W'(1);
        end else if (valid_q && out_meta_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_meta_valid = valid_q;
    assign out_meta_data  = data_q;
    assign out_src_id     = src_q;

`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
    logic [CNT_W-1:0] acc_cnt_q [NUM_IN];
    logic [CNT_W-1:0] stall_cnt_q;

    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                acc_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                acc_cnt_q[grant_idx] <= acc_cnt_q[grant_idx] + CNT_W'(1);
            end
            if (valid_q && !out_meta_ready) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        stats_accept_cnt = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            stats_accept_cnt[i*CNT_W +: CNT_W] = acc_cnt_q[i];
        end
    end

    assign stats_stall_cnt = stall_cnt_q;
`else
    // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_flow_director_arbiter.sv
// Scoreboard bench for flow_director_arbiter: a 4-input/512-bit instance and a 3-input instance.
module tb_flow_director_arbiter;

    localparam int unsigned N4 = 4;
    localparam int unsigned W4 = 512;
    localparam int unsigned S4 = 2;
    localparam int unsigned N3 = 3;
    localparam int unsigned W3 = 32;
    localparam int unsigned S3 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [N4*W4-1:0] d4_in_data  = '0;
    logic [N4-1:0]    d4_in_valid = '0;
    logic [N4-1:0]    d4_in_ready;
    logic [W4-1:0]    d4_out_data;
    logic             d4_out_valid;
    logic             d4_out_ready = 1'b1;
    logic [S4-1:0]    d4_src;

    logic [N3*W3-1:0] d3_in_data  = '0;
    logic [N3-1:0]    d3_in_valid = '0;
    logic [N3-1:0]    d3_in_ready;
    logic [W3-1:0]    d3_out_data;
    logic             d3_out_valid;
    logic             d3_out_ready = 1'b1;
    logic [S3-1:0]    d3_src;

`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
    logic [N4*32-1:0] d4_acc_cnt;
    logic [31:0]      d4_stall_cnt;
    logic [N3*32-1:0] d3_acc_cnt;
    logic [31:0]      d3_stall_cnt;
`endif

    flow_director_arbiter #(.NUM_IN(N4), .META_WIDTH(W4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .in_meta_data   (d4_in_data),
        .in_meta_valid  (d4_in_valid),
        .in_meta_ready  (d4_in_ready),
        .out_meta_data  (d4_out_data),
        .out_meta_valid (d4_out_valid),
        .out_meta_ready (d4_out_ready),
        .out_src_id     (d4_src)
`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
       ,.stats_accept_cnt (d4_acc_cnt),
        .stats_stall_cnt  (d4_stall_cnt)
`endif
    );

    flow_director_arbiter #(.NUM_IN(N3), .META_WIDTH(W3)) dut3 (
        .clk            (clk),
        .rst            (rst),
        .in_meta_data   (d3_in_data),
        .in_meta_valid  (d3_in_valid),
        .in_meta_ready  (d3_in_ready),
        .out_meta_data  (d3_out_data),
        .out_meta_valid (d3_out_valid),
        .out_meta_ready (d3_out_ready),
        .out_src_id     (d3_src)
`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
       ,.stats_accept_cnt (d3_acc_cnt),
        .stats_stall_cnt  (d3_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [S4-1:0] src;
        logic [W4-1:0] data;
    } exp4_t;

    typedef struct {
        logic [S3-1:0] src;
        logic [W3-1:0] data;
    } exp3_t;

    exp4_t q4[$];
    exp3_t q3[$];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [W4-1:0] act, input logic [W4-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (rst === 1'b0 && d4_out_valid === 1'b1 && d4_out_ready === 1'b1) begin
            if (q4.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL d4_unexpected_beat: got src %0d with no expected beat", d4_src);
            end else begin
                exp4_t e;
                e = q4.pop_front();
                chk("d4_out_src", 64'(d4_src), 64'(e.src));
                chk_wide("d4_out_data", d4_out_data, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && d3_out_valid === 1'b1 && d3_out_ready === 1'b1) begin
            if (q3.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL d3_unexpected_beat: got src %0d with no expected beat", d3_src);
            end else begin
                exp3_t e;
                e = q3.pop_front();
                chk("d3_out_src", 64'(d3_src), 64'(e.src));
                chk("d3_out_data", 64'(d3_out_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int i, input logic [31:0] v);
        d4_in_data[i*W4 +: W4] = W4'(v);
    endtask

    task automatic push4(input int s, input logic [31:0] v);
        exp4_t e;
        e.src  = S4'(s);
        e.data = W4'(v);
        q4.push_back(e);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        d4_in_valid  = '0;
        d3_in_valid  = '0;
        d4_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [N4-1:0] e4;
        logic [N3-1:0] e3;

        // Reset values, with requests present during reset.
        rst         = 1'b1;
        d4_in_valid = 4'b1111;
        d3_in_valid = 3'b111;
        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(d4_out_valid), 64'd0);
        chk("rst_out_src", 64'(d4_src), 64'd0);
        chk("rst_out_data_zero", 64'(d4_out_data == '0), 64'd1);
        chk("rst_in_ready", 64'(d4_in_ready), 64'd0);
        chk("rst_in_ready3", 64'(d3_in_ready), 64'd0);
        tick();
        d4_in_valid = '0;
        d3_in_valid = '0;
        rst         = 1'b0;

        // Single requester 2.
        set4(2, 32'hA5);
        d4_in_valid = 4'b0100;
        @(negedge clk);
        chk("single_in_ready", 64'(d4_in_ready), 64'b0100);
        push4(2, 32'hA5);
        tick();
        d4_in_valid = '0;
        @(negedge clk);
        chk("single_out_valid", 64'(d4_out_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("single_drain_valid", 64'(d4_out_valid), 64'd0);
        chk("single_drain_src_hold", 64'(d4_src), 64'd2);
        tick();

        // All four continuously valid: 0,1,2,3,0,1,2,3 with no bubbles.
        do_reset();
        for (int i = 0; i < 4; i++) set4(i, 32'h100 + 32'(i));
        d4_in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k > 0) chk("rr_out_valid", 64'(d4_out_valid), 64'd1);
            e4 = 4'b0001 << (k % 4);
            chk("rr_in_ready", 64'(d4_in_ready), 64'(e4));
            push4(k % 4, 32'h100 + 32'(k % 4));
            tick();
        end
        d4_in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rr_drain_valid", 64'(d4_out_valid), 64'd0);
        tick();

        // Requesters 1 and 3 with 5 cycles of backpressure.
        do_reset();
        set4(1, 32'h11);
        set4(3, 32'h33);
        d4_in_valid = 4'b1010;
        @(negedge clk);
        chk("bp_first_ready", 64'(d4_in_ready), 64'b0010);
        push4(1, 32'h11);
        tick();
        d4_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(d4_in_ready), 64'd0);
            chk("bp_out_valid", 64'(d4_out_valid), 64'd1);
            chk("bp_out_src", 64'(d4_src), 64'd1);
            chk("bp_out_data", 64'(d4_out_data[31:0]), 64'h11);
            tick();
        end
        d4_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(d4_in_ready), 64'b1000);
        push4(3, 32'h33);
        tick();
        @(negedge clk);
        chk("bp_next_ready", 64'(d4_in_ready), 64'b0010);
        push4(1, 32'h11);
        tick();
        d4_in_valid = '0;
        @(negedge clk);
        tick();

        // Reset while a beat is held; pointer must return to 0.
        do_reset();
        set4(0, 32'h77);
        set4(1, 32'h88);
        d4_in_valid  = 4'b0011;
        d4_out_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_pre_ready", 64'(d4_in_ready), 64'b0001);
        tick();
        rst          = 1'b1;
        d4_out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(d4_in_ready), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(d4_out_valid), 64'd0);
        chk("mid_rst_out_src", 64'(d4_src), 64'd0);
        chk("mid_rst_first_grant", 64'(d4_in_ready), 64'b0001);
        push4(0, 32'h77);
        tick();
        d4_in_valid = '0;
        @(negedge clk);
        tick();

        // 10 accepts from requester 1, then 3 stall cycles.
        do_reset();
        set4(1, 32'h5A5A);
        d4_in_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stat_in_ready", 64'(d4_in_ready), 64'b0010);
            push4(1, 32'h5A5A);
            tick();
        end
        d4_in_valid  = '0;
        d4_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stat_stall_valid", 64'(d4_out_valid), 64'd1);
            tick();
        end
        d4_out_ready = 1'b1;
        @(negedge clk);
        tick();
`ifdef FLOW_DIRECTOR_ARBITER_STATS_EN
        @(negedge clk);
        chk("stat_acc0", 64'(d4_acc_cnt[0*32 +: 32]), 64'd0);
        chk("stat_acc1", 64'(d4_acc_cnt[1*32 +: 32]), 64'd10);
        chk("stat_acc2", 64'(d4_acc_cnt[2*32 +: 32]), 64'd0);
        chk("stat_acc3", 64'(d4_acc_cnt[3*32 +: 32]), 64'd0);
        chk("stat_stall", 64'(d4_stall_cnt), 64'd3);
        tick();
`endif

        // Three-input instance: srcs 0,1,2,0,1,2 (non-power-of-2 wrap).
        do_reset();
        for (int i = 0; i < 3; i++) d3_in_data[i*W3 +: W3] = 32'h30 + 32'(i);
        d3_in_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp3_t e;
            @(negedge clk);
            e3 = 3'b001 << (k % 3);
            chk("n3_in_ready", 64'(d3_in_ready), 64'(e3));
            if (k > 0) chk("n3_out_valid", 64'(d3_out_valid), 64'd1);
            e.src  = S3'(k % 3);
            e.data = 32'h30 + 32'(k % 3);
            q3.push_back(e);
            tick();
        end
        d3_in_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("n3_drain_valid", 64'(d3_out_valid), 64'd0);

        chk("q4_empty", 64'(q4.size()), 64'd0);
        chk("q3_empty", 64'(q3.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
